traffic_lights_monitor: RTL and testbench



---
 rtl/traffic_lights_monitor.sv | 199 +++++++++++++++++++
 tb/tb_traffic_lights_monitor.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_lights_monitor.sv
// Passive decoder for the traffic-light lamp outputs: measures segment lengths,
// classifies the operating mode, counts green blinks and flags illegal sequences.
module traffic_lights_monitor #(
    parameter int unsigned CNT_W       = 16,
    parameter logic [15:0] BLINK_MAX   = 16'd600,
    parameter logic [15:0] OFF_TIMEOUT = 16'd2000,
    parameter int unsigned BLINK_CNT_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   red_i,
    input  logic                   yellow_i,
    input  logic                   green_i,
    output logic                   seg_valid_o,
    output logic [2:0]             seg_lights_o,
    output logic [CNT_W-1:0]       seg_len_o,
    output logic [1:0]             mode_o,
    output logic [BLINK_CNT_W-1:0] green_blinks_o,
    output logic                   green_blinks_valid_o,
    output logic                   seq_err_o
);

    localparam logic [2:0] P_DARK    = 3'b000;
    localparam logic [2:0] P_GREEN   = 3'b001;
    localparam logic [2:0] P_YELLOW  = 3'b010;
    localparam logic [2:0] P_RED     = 3'b100;
    localparam logic [2:0] P_RED_YEL = 3'b110;

    typedef enum logic [1:0] {
        MODE_UNKNOWN = 2'd0,
        MODE_NORMAL  = 2'd1,
        MODE_OFF     = 2'd2,
        MODE_UNC     = 2'd3
    } mode_t;

    logic [2:0]             lights_now;
    logic [2:0]             lights_reg;
    logic [2:0]             prev_lights_reg;
    logic                   prev_short_reg;
    logic [CNT_W-1:0]       run_len_reg;
    logic [CNT_W-1:0]       run_len_next;
    logic [31:0]            run_len_ext;
    logic                   green_phase_reg;
    logic                   green_phase_next;
    logic [BLINK_CNT_W-1:0] blink_cnt_reg;
    logic [BLINK_CNT_W-1:0] blink_cnt_next;
    logic [BLINK_CNT_W-1:0] green_blinks_reg;
    logic [BLINK_CNT_W-1:0] green_blinks_next;
    logic                   blinks_valid_reg;
    logic                   blinks_valid_next;
    logic                   seg_valid_reg;
    logic [2:0]             seg_lights_reg;
    logic [CNT_W-1:0]       seg_len_reg;
    logic                   seq_err_reg;
    logic                   seq_err_next;
    mode_t                  mode_reg;
    mode_t                  mode_next;

    logic changed;
    logic seg_done;
    logic cur_alt;
    logic cur_short;
    logic illegal_pat;
    logic bad_trans;
    logic normal_hit;
    logic off_hit;
    logic unc_hit;

    assign lights_now  = {red_i, yellow_i, green_i};
    assign run_len_ext = 32'(run_len_reg);
    assign changed     = (lights_now != lights_reg);
    assign seg_done    = changed && (run_len_reg != '0);
    assign cur_alt     = (lights_reg == P_DARK) || (lights_reg == P_YELLOW);
    assign cur_short   = cur_alt && (run_len_ext <= 32'(BLINK_MAX));

    assign illegal_pat = (lights_now == 3'b101) || (lights_now == 3'b011) ||
                         (lights_now == 3'b111);
    assign bad_trans   = ((lights_now == P_RED_YEL) && (lights_reg != P_RED)) ||
                         ((lights_now == P_GREEN) &&
                          !((lights_reg == P_RED_YEL) ||
                            ((lights_reg == P_DARK) && green_phase_reg)));
    assign seq_err_next = changed && (illegal_pat || bad_trans);

    assign normal_hit = changed && (lights_reg == P_RED) && (lights_now == P_RED_YEL);
    assign off_hit    = !changed && (lights_reg == P_DARK) &&
                        (run_len_ext == 32'(OFF_TIMEOUT));
    // Completed segment and its predecessor are a short dark and a short yellow, either order.
    assign unc_hit    = seg_done && cur_short && prev_short_reg &&
                        ((prev_lights_reg ^ lights_reg) == P_YELLOW);

    assign run_len_next = changed ? CNT_W'(1) :
                          (&run_len_reg) ? run_len_reg : run_len_reg + CNT_W'(1);

    always_comb begin
        green_phase_next  = green_phase_reg;
        blink_cnt_next    = blink_cnt_reg;
        green_blinks_next = green_blinks_reg;
        blinks_valid_next = 1'b0;
        if (changed) begin
            if ((lights_reg == P_RED_YEL) && (lights_now == P_GREEN)) begin
                green_phase_next = 1'b1;
            end else if (green_phase_reg && (lights_reg == P_DARK) &&
                         (lights_now == P_GREEN)) begin
                if (!(&blink_cnt_reg)) begin
                    blink_cnt_next = blink_cnt_reg + BLINK_CNT_W'(1);
                end
            end else if (green_phase_reg &&
                         ((lights_reg == P_DARK) || (lights_reg == P_GREEN)) &&
                         (lights_now != P_DARK) && (lights_now != P_GREEN)) begin
                green_blinks_next = blink_cnt_reg;
                blinks_valid_next = 1'b1;
                blink_cnt_next    = '0;
                green_phase_next  = 1'b0;
            end
        end
    end

    // Mode FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_reg <= MODE_UNKNOWN;
        end else begin
            mode_reg <= mode_next;
        end
    end

    // Mode FSM: next state, highest-priority rule first
    always_comb begin
        mode_next = mode_reg;
        if (normal_hit) begin
            mode_next = MODE_NORMAL;
        end else if (changed && illegal_pat) begin
            mode_next = MODE_UNKNOWN;
        end else if (off_hit) begin
            mode_next = MODE_OFF;
        end else if (unc_hit) begin
            mode_next = MODE_UNC;
        end else begin
            case (mode_reg)
                MODE_OFF: begin
                    if (changed) mode_next = MODE_UNKNOWN;
                end
                MODE_UNC: begin
                    if (changed || (cur_alt && (run_len_ext > 32'(BLINK_MAX)))) begin
                        mode_next = MODE_UNKNOWN;
                    end
                end
                default: begin
                    mode_next = mode_reg;
                end
            endcase
        end
    end

    // Mode FSM: outputs
    always_comb begin
        mode_o = mode_reg;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lights_reg       <= P_DARK;
            run_len_reg      <= '0;
            prev_lights_reg  <= P_DARK;
            prev_short_reg   <= 1'b0;
            green_phase_reg  <= 1'b0;
            blink_cnt_reg    <= '0;
            green_blinks_reg <= '0;
            blinks_valid_reg <= 1'b0;
            seg_valid_reg    <= 1'b0;
            seg_lights_reg   <= '0;
            seg_len_reg      <= '0;
            seq_err_reg      <= 1'b0;
        end else begin
            lights_reg       <= lights_now;
            run_len_reg      <= run_len_next;
            green_phase_reg  <= green_phase_next;
            blink_cnt_reg    <= blink_cnt_next;
            green_blinks_reg <= green_blinks_next;
            blinks_valid_reg <= blinks_valid_next;
            seq_err_reg      <= seq_err_next;
            seg_valid_reg    <= seg_done;
            if (seg_done) begin
                seg_lights_reg  <= lights_reg;
                seg_len_reg     <= run_len_reg;
                prev_lights_reg <= lights_reg;
                prev_short_reg  <= cur_short;
            end
        end
    end

    assign seg_valid_o          = seg_valid_reg;
    assign seg_lights_o         = seg_lights_reg;
    assign seg_len_o            = seg_len_reg;
    assign green_blinks_o       = green_blinks_reg;
    assign green_blinks_valid_o = blinks_valid_reg;
    assign seq_err_o            = seq_err_reg;

endmodule

// File: tb/tb_traffic_lights_monitor.sv
// Bench for traffic_lights_monitor: directed scenarios plus randomized lamp traffic,
// all outputs compared every cycle against a segment-level reference model.
module tb_traffic_lights_monitor;

    localparam int BMAX = 8;
    localparam int OFFT = 20;

    logic clk_i    = 1'b0;
    logic rst_i    = 1'b1;
    logic red_i    = 1'b0;
    logic yellow_i = 1'b0;
    logic green_i  = 1'b0;

    logic        seg_valid;
    logic [2:0]  seg_lights;
    logic [15:0] seg_len;
    logic [1:0]  mode;
    logic [7:0]  gb;
    logic        gbv;
    logic        err;

    logic        seg_valid4;
    logic [2:0]  seg_lights4;
    logic [3:0]  seg_len4;
    logic [1:0]  mode4;
    logic [7:0]  gb4;
    logic        gbv4;
    logic        err4;

    traffic_lights_monitor #(
        .CNT_W(16), .BLINK_MAX(16'(BMAX)), .OFF_TIMEOUT(16'(OFFT)), .BLINK_CNT_W(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .red_i(red_i), .yellow_i(yellow_i), .green_i(green_i),
        .seg_valid_o(seg_valid), .seg_lights_o(seg_lights), .seg_len_o(seg_len),
        .mode_o(mode), .green_blinks_o(gb), .green_blinks_valid_o(gbv), .seq_err_o(err)
    );

    traffic_lights_monitor #(
        .CNT_W(4), .BLINK_MAX(16'(BMAX)), .OFF_TIMEOUT(16'(OFFT)), .BLINK_CNT_W(8)
    ) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .red_i(red_i), .yellow_i(yellow_i), .green_i(green_i),
        .seg_valid_o(seg_valid4), .seg_lights_o(seg_lights4), .seg_len_o(seg_len4),
        .mode_o(mode4), .green_blinks_o(gb4), .green_blinks_valid_o(gbv4), .seq_err_o(err4)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int seg_log[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (segment level) ----------------
    typedef struct {
        bit [2:0] pat;
        int       len;
    } seg_t;

    seg_t     hist[$];
    bit [2:0] m_pat = 3'b000;
    int       m_len = 0;
    bit       m_green = 1'b0;
    int       m_blinks = 0;
    int       m_mode = 0;
    int e_sv = 0, e_sl = 0, e_len = 0, e_mode = 0, e_gb = 0, e_gbv = 0, e_err = 0;

    function automatic bit short_alt(input seg_t sg);
        return ((sg.pat == 3'b000) || (sg.pat == 3'b010)) && (sg.len <= BMAX);
    endfunction

    task automatic model_reset();
        hist.delete();
        m_pat = 3'b000; m_len = 0; m_green = 0; m_blinks = 0; m_mode = 0;
        e_sv = 0; e_sl = 0; e_len = 0; e_mode = 0; e_gb = 0; e_gbv = 0; e_err = 0;
    endtask

    task automatic model_step(input bit [2:0] s);
        int   nm;
        bit   done, ill_pat, ill_tr;
        seg_t sg;
        nm = m_mode;
        e_sv = 0; e_gbv = 0; e_err = 0;
        if (s != m_pat) begin
            done = (m_len > 0);
            sg.pat = m_pat;
            sg.len = m_len;
            if (done) begin
                e_sv = 1; e_sl = m_pat; e_len = m_len;
                hist.push_back(sg);
                if (hist.size() > 2) void'(hist.pop_front());
            end
            ill_pat = (s == 3'b101) || (s == 3'b011) || (s == 3'b111);
            ill_tr  = ((s == 3'b110) && (m_pat != 3'b100)) ||
                      ((s == 3'b001) && !((m_pat == 3'b110) || ((m_pat == 3'b000) && m_green)));
            e_err = (ill_pat || ill_tr) ? 1 : 0;
            if ((m_pat == 3'b110) && (s == 3'b001)) begin
                m_green = 1;
            end else if (m_green && (m_pat == 3'b000) && (s == 3'b001)) begin
                if (m_blinks < 255) m_blinks++;
            end else if (m_green && (m_pat <= 3'b001) && (s > 3'b001)) begin
                e_gb = m_blinks; e_gbv = 1; m_blinks = 0; m_green = 0;
            end
            if ((m_pat == 3'b100) && (s == 3'b110)) nm = 1;
            else if (ill_pat) nm = 0;
            else if (done && hist.size() == 2 && short_alt(hist[0]) && short_alt(hist[1]) &&
                     hist[0].pat != hist[1].pat) nm = 3;
            else if (m_mode == 2 || m_mode == 3) nm = 0;
            m_pat = s;
            m_len = 1;
        end else begin
            if ((m_pat == 3'b000) && (m_len == OFFT)) nm = 2;
            else if ((m_mode == 3) && ((m_pat == 3'b000) || (m_pat == 3'b010)) && (m_len > BMAX)) nm = 0;
            if (m_len < 65535) m_len++;
        end
        m_mode = nm;
        e_mode = nm;
    endtask

    initial begin
        forever begin
            @(posedge clk_i or posedge rst_i);
            if (rst_i) model_reset();
            else model_step({red_i, yellow_i, green_i});
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            chk("seg_valid", int'(seg_valid), e_sv);
            chk("seg_lights", int'(seg_lights), e_sl);
            chk("seg_len", int'(seg_len), e_len);
            chk("mode", int'(mode), e_mode);
            chk("green_blinks", int'(gb), e_gb);
            chk("green_blinks_valid", int'(gbv), e_gbv);
            chk("seq_err", int'(err), e_err);
            chk("seg_valid4", int'(seg_valid4), e_sv);
            chk("seg_len4", int'(seg_len4), (e_len > 15) ? 15 : e_len);
            if (err) err_cnt++;
            if (seg_valid) begin
                seg_log.push_back(int'(seg_len));
                $display("seg lights=%b len=%0d mode=%0d err=%0b blinks_valid=%0b blinks=%0d",
                         seg_lights, seg_len, mode, err, gbv, gb);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input bit [2:0] p, input int n);
        {red_i, yellow_i, green_i} = p;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        {red_i, yellow_i, green_i} = 3'b000;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        seg_log.delete();
        err_cnt = 0;
    endtask

    initial begin
        int exp_lens[8] = '{10, 4, 6, 3, 3, 3, 3, 5};
        bit [2:0] p;
        int len;
        int r;

        @(negedge clk_i);
        chk("reset_seg_valid", int'(seg_valid), 0);
        chk("reset_mode", int'(mode), 0);
        chk("reset_err", int'(err), 0);
        do_reset();

        // normal cycle with two green blinks
        hold(3'b100, 10); hold(3'b110, 4); hold(3'b001, 6);
        hold(3'b000, 3);  hold(3'b001, 3); hold(3'b000, 3); hold(3'b001, 3);
        hold(3'b010, 1);
        chk("normal_blinks_valid", int'(gbv), 1);
        chk("normal_blinks", int'(gb), 2);
        hold(3'b010, 4); hold(3'b100, 1);
        chk("normal_seg_count", seg_log.size(), 8);
        for (int i = 0; i < 8 && i < seg_log.size(); i++) chk("normal_seg_len", seg_log[i], exp_lens[i]);
        chk("normal_mode", int'(mode), 1);
        chk("normal_no_err", err_cnt, 0);

        // dark after reset -> OFF exactly after run_len hits 20
        do_reset();
        hold(3'b000, 20);
        chk("off_not_at_20", int'(mode), 0);
        hold(3'b000, 1);
        chk("off_entered", int'(mode), 2);
        hold(3'b000, 4);
        chk("off_no_partial_seg", seg_log.size(), 0);
        hold(3'b100, 1);
        chk("off_leave_mode", int'(mode), 0);
        chk("off_leave_len", int'(seg_len), 25);

        // yellow/dark alternation -> UNC, long yellow -> UNKNOWN
        do_reset();
        hold(3'b010, 3); hold(3'b000, 3); hold(3'b010, 1);
        chk("unc_entered", int'(mode), 3);
        hold(3'b010, 2); hold(3'b000, 3); hold(3'b010, 1);
        chk("unc_held", int'(mode), 3);
        hold(3'b010, 8);
        chk("unc_at_len9", int'(mode), 3);
        hold(3'b010, 1);
        chk("unc_exit", int'(mode), 0);

        // illegal transition and illegal pattern
        do_reset();
        hold(3'b100, 3); hold(3'b110, 2); hold(3'b100, 5); hold(3'b001, 1);
        chk("bad_trans_err", int'(err), 1);
        chk("bad_trans_mode", int'(mode), 1);
        hold(3'b001, 1);
        chk("bad_trans_single", int'(err), 0);
        hold(3'b101, 1);
        chk("bad_pat_err", int'(err), 1);
        chk("bad_pat_mode", int'(mode), 0);

        // saturation of the 4-bit segment counter
        do_reset();
        hold(3'b100, 30); hold(3'b110, 1);
        chk("sat4_valid", int'(seg_valid4), 1);
        chk("sat4_len", int'(seg_len4), 15);
        chk("sat16_len", int'(seg_len), 30);

        // asynchronous reset mid-green
        do_reset();
        hold(3'b100, 3); hold(3'b110, 2); hold(3'b001, 3);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_mode", int'(mode), 0);
        chk("arst_seg_lights", int'(seg_lights), 0);
        chk("arst_seg_len", int'(seg_len), 0);
        chk("arst_seg_valid", int'(seg_valid), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        seg_log.delete();
        hold(3'b001, 4);
        chk("arst_no_seg", seg_log.size(), 0);
        hold(3'b000, 1);
        chk("arst_first_len", int'(seg_len), 4);

        // randomized traffic
        do_reset();
        p = 3'b100;
        for (int k = 0; k < 350; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 12) begin
                p = 3'($urandom_range(0, 7));
            end else begin
                case (p)
                    3'b100: p = (r < 80) ? 3'b110 : 3'b010;
                    3'b110: p = 3'b001;
                    3'b001: p = (r < 70) ? 3'b000 : 3'b010;
                    3'b000: p = (r < 50) ? 3'b001 : ((r < 80) ? 3'b010 : 3'b100);
                    3'b010: p = (r < 60) ? 3'b000 : 3'b100;
                    default: p = 3'b100;
                endcase
            end
            len = int'($urandom_range(1, 11));
            if (p == 3'b000 && r > 92) len = int'($urandom_range(18, 26));
            if (r == 99) begin
                #3 rst_i = 1'b1;
                @(negedge clk_i);
                rst_i = 1'b0;
            end
            hold(p, len);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
